// File: rtl/median_window_gen.sv
// ---------------------------------------------------------------------------
// median_window_gen
//
// Streaming 3x3 neighbourhood generator for the median filter stage.
// Pixels arrive one per accepted cycle in scan order (fast dimension ROW,
// slow dimension COL). For each pixel the block emits its nine window taps
// and its scan index. Taps that fall outside the image are driven as zero.
//
// Tap k = 3*dc + dr (dc, dr in 0..2) carries image[(c+dc-1)*ROW + (r+dr-1)],
// where (r, c) is the position of the window centre.
//
// Parameters
//   ROW          samples per line (fast scan dimension)
//   COL          lines per frame  (slow scan dimension)
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous, active-high reset
//   in_valid     in_data is presented this cycle
//   in_data      8-bit pixel sample
//   in_ready     block can accept in_data this cycle
//   out_valid    window taps and pixel are valid this cycle
//   pixel        signed scan index of the window centre (holds N after a frame)
//   data_out_0..8  window taps
//   frame_done   one-cycle pulse with the output for the last pixel
// ---------------------------------------------------------------------------
module median_window_gen #(
    parameter int ROW = 554,
    parameter int COL = 430
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic signed [31:0] pixel,
    output logic [7:0]         data_out_0,
    output logic [7:0]         data_out_1,
    output logic [7:0]         data_out_2,
    output logic [7:0]         data_out_3,
    output logic [7:0]         data_out_4,
    output logic [7:0]         data_out_5,
    output logic [7:0]         data_out_6,
    output logic [7:0]         data_out_7,
    output logic [7:0]         data_out_8,
    output logic               frame_done
);

    // state    | meaning
    // ---------+-----------------------------------------------------------
    // ST_FILL  | accepting the first ROW+2 samples; the last of them
    //          | produces the output for pixel 0
    // ST_RUN   | each accepted sample i produces the output for i-ROW-1
    // ST_FLUSH | no input; emits the last ROW+1 outputs one per cycle

    localparam logic [31:0] L_ROW      = 32'(ROW);
    localparam logic [31:0] L_COL      = 32'(COL);
    localparam logic [31:0] L_N        = 32'(ROW * COL);
    localparam logic [31:0] L_LAST     = L_N - 32'd1;
    localparam logic [31:0] L_FILL_END = L_ROW + 32'd1;

    // Two line buffers of depth ROW laid end to end, with the window
    // columns folded into the same chain. r_line[j] holds the sample
    // accepted j+1 shifts ago.
    localparam int DEPTH = 2 * ROW + 2;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_in_cnt;
    logic [31:0] r_out_cnt;
    logic [31:0] r_r;
    logic [31:0] r_c;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_frame_done;
    logic [31:0] r_pixel;
    logic [7:0]  r_tap  [0:8];
    logic [7:0]  r_line [0:DEPTH-1];

    logic        w_accept;
    logic        w_flush;
    logic        w_shift;
    logic        w_emit;
    logic [7:0]  w_din;
    logic [2:0]  w_col_ok;
    logic [2:0]  w_row_ok;
    logic [7:0]  w_raw  [0:8];
    logic [7:0]  w_tap  [0:8];

    assign w_accept = in_valid & r_in_ready;
    assign w_flush  = (r_state == ST_FLUSH);
    // During flush the chain keeps advancing with zeros so every tap stays
    // aligned to the centre; any tap that would read a flushed zero lies
    // outside the image and is masked anyway.
    assign w_shift  = w_accept | w_flush;
    assign w_emit   = (w_accept & (r_in_cnt >= L_FILL_END)) | w_flush;
    assign w_din    = w_accept ? in_data : 8'd0;

    // Taps are taken before this cycle's shift; the incoming sample itself
    // is the bottom-right tap of the window being emitted.
    assign w_raw[8] = w_din;
    assign w_raw[7] = r_line[0];
    assign w_raw[6] = r_line[1];
    assign w_raw[5] = r_line[ROW - 1];
    assign w_raw[4] = r_line[ROW];
    assign w_raw[3] = r_line[ROW + 1];
    assign w_raw[2] = r_line[2 * ROW - 1];
    assign w_raw[1] = r_line[2 * ROW];
    assign w_raw[0] = r_line[2 * ROW + 1];

    // Explicit bound checks on both dimensions; without the row check the
    // chain would hand over samples from the neighbouring line.
    assign w_col_ok = {(r_c != L_COL - 32'd1), 1'b1, (r_c != 32'd0)};
    assign w_row_ok = {(r_r != L_ROW - 32'd1), 1'b1, (r_r != 32'd0)};

    for (genvar gc = 0; gc < 3; gc++) begin : g_dc
        for (genvar gr = 0; gr < 3; gr++) begin : g_dr
            assign w_tap[3*gc+gr] = (w_col_ok[gc] && w_row_ok[gr]) ?
                                    w_raw[3*gc+gr] : 8'd0;
        end
    end

    // Line storage carries no reset so it can map onto shift-register
    // primitives; stale contents are never exposed because out-of-frame
    // taps are masked.
    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_line[0] <= w_din;
            for (int j = 1; j < DEPTH; j++) begin
                r_line[j] <= r_line[j-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_in_cnt     <= 32'd0;
            r_out_cnt    <= 32'd0;
            r_r          <= 32'd0;
            r_c          <= 32'd0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_pixel      <= 32'd0;
            for (int k = 0; k < 9; k++) begin
                r_tap[k] <= 8'd0;
            end
        end else begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;

            // Park the index at N once a frame completes so the downstream
            // filter sees pixel >= N and raises its done.
            if (r_frame_done) begin
                r_pixel <= L_N;
            end

            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_pixel     <= r_out_cnt;
                for (int k = 0; k < 9; k++) begin
                    r_tap[k] <= w_tap[k];
                end
                if (r_out_cnt == L_LAST) begin
                    r_frame_done <= 1'b1;
                    r_out_cnt    <= 32'd0;
                    r_r          <= 32'd0;
                    r_c          <= 32'd0;
                end else begin
                    r_out_cnt <= r_out_cnt + 32'd1;
                    if (r_r == L_ROW - 32'd1) begin
                        r_r <= 32'd0;
                        r_c <= r_c + 32'd1;
                    end else begin
                        r_r <= r_r + 32'd1;
                    end
                end
            end

            case (r_state)
                ST_FILL: begin
                    // in_ready is low only on the first cycle after reset
                    // or after the frame_done cycle.
                    if (!r_in_ready) begin
                        r_in_ready <= 1'b1;
                    end else if (w_accept) begin
                        r_in_cnt <= r_in_cnt + 32'd1;
                        if (r_in_cnt == L_FILL_END) begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        if (r_in_cnt == L_LAST) begin
                            r_in_cnt   <= 32'd0;
                            r_in_ready <= 1'b0;
                            r_state    <= ST_FLUSH;
                        end else begin
                            r_in_cnt <= r_in_cnt + 32'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (r_out_cnt == L_LAST) begin
                        r_state <= ST_FILL;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;
    assign pixel      = signed'(r_pixel);
    assign data_out_0 = r_tap[0];
    assign data_out_1 = r_tap[1];
    assign data_out_2 = r_tap[2];
    assign data_out_3 = r_tap[3];
    assign data_out_4 = r_tap[4];
    assign data_out_5 = r_tap[5];
    assign data_out_6 = r_tap[6];
    assign data_out_7 = r_tap[7];
    assign data_out_8 = r_tap[8];

endmodule

// File: tb/tb_median_window_gen.sv
// ---------------------------------------------------------------------------
// tb_median_window_gen
//
// Directed bench for median_window_gen with ROW=4, COL=3 (N=12).
// A negedge monitor logs every valid output; scenario tasks drive frames
// and compare the log against hand-computed windows.
// ---------------------------------------------------------------------------
module tb_median_window_gen;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic [7:0]         in_data = 8'd0;
    logic               in_ready;
    logic               out_valid;
    logic signed [31:0] pixel;
    logic [7:0]         data_out_0, data_out_1, data_out_2;
    logic [7:0]         data_out_3, data_out_4, data_out_5;
    logic [7:0]         data_out_6, data_out_7, data_out_8;
    logic               frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    int          cyc = 0;
    logic        prev_acc = 1'b0;
    int          viol = 0;
    int          q_pix [$];
    logic [71:0] q_tap [$];
    logic        q_fd  [$];
    logic        q_rdy [$];
    int          q_cyc [$];
    int          acc_cyc [$];

    median_window_gen #(.ROW(4), .COL(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .pixel      (pixel),
        .data_out_0 (data_out_0),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2),
        .data_out_3 (data_out_3),
        .data_out_4 (data_out_4),
        .data_out_5 (data_out_5),
        .data_out_6 (data_out_6),
        .data_out_7 (data_out_7),
        .data_out_8 (data_out_8),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Outputs seen here were launched by the edge numbered cyc; an accept
    // set up now happens at edge cyc+1.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            q_pix.push_back(int'(pixel));
            q_tap.push_back({data_out_8, data_out_7, data_out_6, data_out_5, data_out_4,
                             data_out_3, data_out_2, data_out_1, data_out_0});
            q_fd.push_back(frame_done);
            q_rdy.push_back(in_ready);
            q_cyc.push_back(cyc);
            if (!prev_acc && in_ready === 1'b1) viol = viol + 1;
        end
        prev_acc = (in_valid === 1'b1) && (in_ready === 1'b1);
        if (prev_acc) acc_cyc.push_back(cyc + 1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_checks=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // Reference window for a 4x3 image whose sample at index q is q+base.
    function automatic logic [71:0] exp_win(input int p, input int base);
        logic [71:0] w;
        int r, c, rr, cc;
        w = '0;
        r = p % 4;
        c = p / 4;
        for (int k = 0; k < 9; k++) begin
            rr = r + (k % 3) - 1;
            cc = c + (k / 3) - 1;
            if (rr >= 0 && rr < 4 && cc >= 0 && cc < 3) w[8*k +: 8] = 8'(cc * 4 + rr + base);
        end
        return w;
    endfunction

    task automatic clear_log();
        q_pix.delete();
        q_tap.delete();
        q_fd.delete();
        q_rdy.delete();
        q_cyc.delete();
        acc_cyc.delete();
        viol = 0;
    endtask

    // Presents samples (idx%12)+base until n have been accepted. While
    // in_ready is low a junk value is driven to show it is ignored.
    task automatic drive_stream(input int n, input int base, input int gap_pct, output int accepted);
        int idx, budget;
        idx = 0;
        budget = 0;
        while (idx < n && budget < 400) begin
            @(posedge clk);
            #2;
            budget++;
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) in_valid = 1'b0;
            else in_valid = 1'b1;
            in_data = (in_ready === 1'b1) ? 8'((idx % 12) + base) : 8'hEE;
            if (in_valid && in_ready === 1'b1) idx++;
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        accepted = idx;
    endtask

    task automatic wait_outputs(input int n);
        int b;
        b = 0;
        while (q_pix.size() < n && b < 100) begin
            @(negedge clk);
            b++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else n_pass++;
        n_checks++; if (pixel !== 32'sd0) $display("FAIL reset_pixel: got %0d want 0", pixel); else n_pass++;
        n_checks++;
        if ({data_out_8, data_out_7, data_out_6, data_out_5, data_out_4, data_out_3, data_out_2, data_out_1, data_out_0} !== 72'd0)
            $display("FAIL reset_taps: got %h want 0", {data_out_8, data_out_7, data_out_6, data_out_5, data_out_4, data_out_3, data_out_2, data_out_1, data_out_0});
        else n_pass++;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL release_in_ready_early: got %b want 0", in_ready); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_stream();
        int acc;
        logic [71:0] t0, t4, t5, t11;
        t0  = {8'd6, 8'd5, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        t4  = {8'd10, 8'd9, 8'd0, 8'd6, 8'd5, 8'd0, 8'd2, 8'd1, 8'd0};
        t5  = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
        t11 = {8'd0, 8'd0, 8'd0, 8'd0, 8'd12, 8'd11, 8'd0, 8'd8, 8'd7};
        clear_log();
        drive_stream(12, 1, 0, acc);
        wait_outputs(12);
        n_checks++; if (acc != 12) $display("FAIL stream_accepts: got %0d want 12", acc); else n_pass++;
        n_checks++; if (q_pix.size() != 12) $display("FAIL stream_count: got %0d want 12", q_pix.size()); else n_pass++;
        if (q_pix.size() == 12 && acc_cyc.size() == 12) begin
            n_checks++; if (q_cyc[0] != acc_cyc[5]) $display("FAIL stream_first_latency: out edge %0d accept5 edge %0d", q_cyc[0], acc_cyc[5]); else n_pass++;
            n_checks++; if (q_cyc[11] - acc_cyc[0] != 16) $display("FAIL stream_span: got %0d want 16", q_cyc[11] - acc_cyc[0]); else n_pass++;
            n_checks++; if (q_tap[0] !== t0) $display("FAIL stream_taps_p0: got %h want %h", q_tap[0], t0); else n_pass++;
            n_checks++; if (q_tap[4] !== t4) $display("FAIL stream_taps_p4: got %h want %h", q_tap[4], t4); else n_pass++;
            n_checks++; if (q_tap[5] !== t5) $display("FAIL stream_taps_p5: got %h want %h", q_tap[5], t5); else n_pass++;
            n_checks++; if (q_tap[11] !== t11) $display("FAIL stream_taps_p11: got %h want %h", q_tap[11], t11); else n_pass++;
            for (int j = 0; j < 12; j++) begin
                n_checks++; if (q_pix[j] != j) $display("FAIL stream_pixel[%0d]: got %0d want %0d", j, q_pix[j], j); else n_pass++;
                n_checks++; if (q_tap[j] !== exp_win(j, 1)) $display("FAIL stream_win[%0d]: got %h want %h", j, q_tap[j], exp_win(j, 1)); else n_pass++;
                n_checks++; if (q_fd[j] !== (j == 11)) $display("FAIL stream_frame_done[%0d]: got %b want %b", j, q_fd[j], (j == 11)); else n_pass++;
            end
            n_checks++; if (q_rdy[5] !== 1'b1) $display("FAIL stream_ready_run: got %b want 1", q_rdy[5]); else n_pass++;
            for (int j = 6; j < 12; j++) begin
                n_checks++; if (q_rdy[j] !== 1'b0) $display("FAIL stream_ready_flush[%0d]: got %b want 0", j, q_rdy[j]); else n_pass++;
            end
        end
        n_checks++; if (pixel !== 32'sd12) $display("FAIL stream_pixel_hold: got %0d want 12", pixel); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_idle_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL stream_ready_back: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_gaps();
        int acc;
        clear_log();
        drive_stream(12, 1, 30, acc);
        wait_outputs(12);
        n_checks++; if (acc != 12) $display("FAIL gaps_accepts: got %0d want 12", acc); else n_pass++;
        n_checks++; if (q_pix.size() != 12) $display("FAIL gaps_count: got %0d want 12", q_pix.size()); else n_pass++;
        n_checks++; if (viol != 0) $display("FAIL gaps_valid_without_accept: got %0d want 0", viol); else n_pass++;
        if (q_pix.size() == 12 && acc_cyc.size() == 12) begin
            for (int j = 0; j < 12; j++) begin
                n_checks++; if (q_pix[j] != j) $display("FAIL gaps_pixel[%0d]: got %0d want %0d", j, q_pix[j], j); else n_pass++;
                n_checks++; if (q_tap[j] !== exp_win(j, 1)) $display("FAIL gaps_win[%0d]: got %h want %h", j, q_tap[j], exp_win(j, 1)); else n_pass++;
            end
            for (int j = 0; j < 7; j++) begin
                n_checks++; if (q_cyc[j] != acc_cyc[j+5]) $display("FAIL gaps_latency[%0d]: out edge %0d accept edge %0d", j, q_cyc[j], acc_cyc[j+5]); else n_pass++;
            end
            n_checks++; if (q_fd[11] !== 1'b1) $display("FAIL gaps_frame_done: got %b want 1", q_fd[11]); else n_pass++;
        end
    endtask

    task automatic test_midreset();
        int acc;
        logic [71:0] r0;
        r0 = {8'd106, 8'd105, 8'd0, 8'd102, 8'd101, 8'd0, 8'd0, 8'd0, 8'd0};
        clear_log();
        drive_stream(8, 1, 0, acc);
        n_checks++; if (out_valid !== 1'b1 || pixel !== 32'sd2) $display("FAIL midreset_before: valid %b pixel %0d want 1/2", out_valid, pixel); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL midreset_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (pixel !== 32'sd0) $display("FAIL midreset_pixel: got %0d want 0", pixel); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL midreset_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++;
        if ({data_out_8, data_out_7, data_out_6, data_out_5, data_out_4, data_out_3, data_out_2, data_out_1, data_out_0} !== 72'd0)
            $display("FAIL midreset_taps: got %h want 0", {data_out_8, data_out_7, data_out_6, data_out_5, data_out_4, data_out_3, data_out_2, data_out_1, data_out_0});
        else n_pass++;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        clear_log();
        drive_stream(12, 101, 0, acc);
        wait_outputs(12);
        n_checks++; if (q_pix.size() != 12) $display("FAIL midreset_count: got %0d want 12", q_pix.size()); else n_pass++;
        if (q_pix.size() == 12) begin
            n_checks++; if (q_pix[0] != 0) $display("FAIL midreset_first_pixel: got %0d want 0", q_pix[0]); else n_pass++;
            n_checks++; if (q_tap[0] !== r0) $display("FAIL midreset_first_taps: got %h want %h", q_tap[0], r0); else n_pass++;
            for (int j = 1; j < 12; j++) begin
                n_checks++; if (q_tap[j] !== exp_win(j, 101)) $display("FAIL midreset_win[%0d]: got %h want %h", j, q_tap[j], exp_win(j, 101)); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        clear_log();
        drive_stream(24, 1, 0, acc);
        wait_outputs(24);
        n_checks++; if (acc != 24) $display("FAIL b2b_accepts: got %0d want 24", acc); else n_pass++;
        n_checks++; if (q_pix.size() != 24) $display("FAIL b2b_count: got %0d want 24", q_pix.size()); else n_pass++;
        if (q_pix.size() == 24 && acc_cyc.size() == 24) begin
            n_checks++; if (acc_cyc[12] != q_cyc[11] + 2) $display("FAIL b2b_restart: accept edge %0d want %0d", acc_cyc[12], q_cyc[11] + 2); else n_pass++;
            n_checks++; if (q_cyc[12] != acc_cyc[17]) $display("FAIL b2b_latency: out edge %0d want %0d", q_cyc[12], acc_cyc[17]); else n_pass++;
            n_checks++; if (q_fd[11] !== 1'b1 || q_fd[23] !== 1'b1) $display("FAIL b2b_frame_done: got %b/%b want 1/1", q_fd[11], q_fd[23]); else n_pass++;
            for (int j = 0; j < 24; j++) begin
                n_checks++; if (q_pix[j] != j % 12) $display("FAIL b2b_pixel[%0d]: got %0d want %0d", j, q_pix[j], j % 12); else n_pass++;
                n_checks++; if (q_tap[j] !== exp_win(j % 12, 1)) $display("FAIL b2b_win[%0d]: got %h want %h", j, q_tap[j], exp_win(j % 12, 1)); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_midreset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
